// File: rtl/params_loader_pkg.sv
// Shared types for the parameter loader: word/address types, access width and FSM states.
package params_loader_pkg;

    localparam int unsigned ParamWidth = 16;
    localparam int unsigned AddrWidth  = 8;

    typedef logic [ParamWidth-1:0] Param_t;
    typedef logic [AddrWidth-1:0]  ParamAddr_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } ParamLoaderState_t;

    // Rotate left by one bit; the building block of the order-sensitive checksum.
    function automatic Param_t rotl1(input Param_t x);
        return {x[ParamWidth-2:0], x[ParamWidth-1]};
    endfunction

endpackage

// File: rtl/param_checksum.sv
// Rotate-XOR accumulator: cs <= rotl(cs,1) ^ data on each enabled cycle, clear has priority.
module param_checksum
    import params_loader_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   en_i,
    input  Param_t data_i,
    output Param_t cs_o
);

    Param_t cs_q, cs_d;

    // Next accumulator value.
    always_comb begin
        cs_d = cs_q;
        if (clear_i) begin
            cs_d = '0;
        end else if (en_i) begin
            cs_d = rotl1(cs_q) ^ data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_q <= '0;
        end else begin
            cs_q <= cs_d;
        end
    end

    assign cs_o = cs_q;

endmodule

// File: rtl/params_loader.sv
// Write-side initiator for params_mem: streams words into sequential addresses, then
// optionally re-reads the range and compares write/read checksums.
module params_loader
    import params_loader_pkg::*;
#(
    parameter bit          VERIFY_EN    = 1'b1,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    input  ParamAddr_t start_addr_i,
    input  ParamAddr_t num_words_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  Param_t     in_data_i,
    output logic       mem_write_en_o,
    output logic       mem_chip_en_o,
    output ParamAddr_t mem_write_addr_o,
    output Param_t     mem_write_data_o,
    output DataWidth_t mem_write_data_width_o,
    output logic       mem_read_en_o,
    output ParamAddr_t mem_read_addr_o,
    output DataWidth_t mem_read_data_width_o,
    input  Param_t     mem_read_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o
);

    ParamLoaderState_t state_q, state_d;
    ParamAddr_t start_addr_q, start_addr_d;
    ParamAddr_t num_words_q, num_words_d;
    ParamAddr_t wr_count_q, wr_count_d;
    ParamAddr_t rd_issue_q, rd_issue_d;
    ParamAddr_t rd_ret_q, rd_ret_d;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic       we_q, we_d;
    ParamAddr_t waddr_q, waddr_d;
    Param_t     wdata_q, wdata_d;
    logic       re_q, re_d;
    ParamAddr_t raddr_q, raddr_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic   accept;
    logic   rd_valid;
    logic   cs_clear;
    Param_t wr_cs, rd_cs;

    assign in_ready_o = (state_q == WRITE) && (wr_count_q < num_words_q);
    assign accept     = in_valid_i && in_ready_o;
    // Top of the latency pipe marks the cycle mem_read_data_i belongs to an issued read.
    assign rd_valid   = rd_pipe_q[READ_LATENCY-1];

    // Next-state, counters, memory strobes and status.
    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        num_words_d  = num_words_q;
        wr_count_d   = wr_count_q;
        rd_issue_d   = rd_issue_q;
        rd_ret_d     = rd_ret_q;
        rd_pipe_d    = (rd_pipe_q << 1) | READ_LATENCY'(re_q);
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        re_d         = 1'b0;
        raddr_d      = raddr_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        cs_clear     = 1'b0;

        if (abort_i) begin
            // In-flight reads are dropped by flushing the valid pipe.
            state_d    = IDLE;
            rd_pipe_d  = '0;
            wr_count_d = '0;
            rd_issue_d = '0;
            rd_ret_d   = '0;
            pass_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_addr_d = start_addr_i;
                        num_words_d  = num_words_i;
                        wr_count_d   = '0;
                        rd_issue_d   = '0;
                        rd_ret_d     = '0;
                        cs_clear     = 1'b1;
                        pass_d       = (num_words_i == '0);
                        state_d      = (num_words_i == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        we_d       = 1'b1;
                        waddr_d    = start_addr_q + wr_count_q;
                        wdata_d    = in_data_i;
                        wr_count_d = wr_count_q + ParamAddr_t'(1);
                        if (wr_count_q == num_words_q - ParamAddr_t'(1)) begin
                            if (VERIFY_EN) begin
                                state_d = VERIFY;
                            end else begin
                                state_d = DONE;
                                pass_d  = 1'b1;
                            end
                        end
                    end
                end
                VERIFY: begin
                    // Registered strobe: first read lands the cycle after the last write.
                    if (rd_issue_q < num_words_q) begin
                        re_d       = 1'b1;
                        raddr_d    = start_addr_q + rd_issue_q;
                        rd_issue_d = rd_issue_q + ParamAddr_t'(1);
                    end
                    if (rd_valid) begin
                        rd_ret_d = rd_ret_q + ParamAddr_t'(1);
                    end
                    // rd_cs already includes the final word once the count has caught up.
                    if (rd_ret_q == num_words_q) begin
                        pass_d  = (rd_cs == wr_cs);
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            start_addr_q <= '0;
            num_words_q  <= '0;
            wr_count_q   <= '0;
            rd_issue_q   <= '0;
            rd_ret_q     <= '0;
            rd_pipe_q    <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            re_q         <= 1'b0;
            raddr_q      <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            num_words_q  <= num_words_d;
            wr_count_q   <= wr_count_d;
            rd_issue_q   <= rd_issue_d;
            rd_ret_q     <= rd_ret_d;
            rd_pipe_q    <= rd_pipe_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            re_q         <= re_d;
            raddr_q      <= raddr_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    param_checksum u_wr_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cs_clear),
        .en_i    (accept && !abort_i),
        .data_i  (in_data_i),
        .cs_o    (wr_cs)
    );

    param_checksum u_rd_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cs_clear),
        .en_i    (rd_valid && (state_q == VERIFY) && !abort_i),
        .data_i  (mem_read_data_i),
        .cs_o    (rd_cs)
    );

    assign mem_write_en_o         = we_q;
    assign mem_write_addr_o       = waddr_q;
    assign mem_write_data_o       = wdata_q;
    assign mem_write_data_width_o = SINGLE_WIDTH;
    assign mem_read_en_o          = re_q;
    assign mem_read_addr_o        = raddr_q;
    assign mem_read_data_width_o  = SINGLE_WIDTH;
    assign mem_chip_en_o          = we_q | re_q;
    assign busy_o                 = (state_q != IDLE);
    assign done_o                 = done_q;
    assign pass_o                 = pass_q;

endmodule

// File: tb/tb_params_loader.sv
// Scoreboard bench for params_loader driving a behavioural params_mem model.
module tb_params_loader;
    import params_loader_pkg::*;

    localparam int unsigned RL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    ParamAddr_t start_addr = '0, num_words = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    Param_t     in_data = '0;
    logic       mem_write_en, mem_chip_en, mem_read_en;
    ParamAddr_t mem_write_addr, mem_read_addr;
    Param_t     mem_write_data, mem_read_data;
    DataWidth_t mem_write_data_width, mem_read_data_width;
    logic       busy, done, pass;

    always #5 clk = ~clk;

    params_loader #(.VERIFY_EN(1'b1), .READ_LATENCY(RL)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .start_i                (start),
        .abort_i                (abort),
        .start_addr_i           (start_addr),
        .num_words_i            (num_words),
        .in_valid_i             (in_valid),
        .in_ready_o             (in_ready),
        .in_data_i              (in_data),
        .mem_write_en_o         (mem_write_en),
        .mem_chip_en_o          (mem_chip_en),
        .mem_write_addr_o       (mem_write_addr),
        .mem_write_data_o       (mem_write_data),
        .mem_write_data_width_o (mem_write_data_width),
        .mem_read_en_o          (mem_read_en),
        .mem_read_addr_o        (mem_read_addr),
        .mem_read_data_width_o  (mem_read_data_width),
        .mem_read_data_i        (mem_read_data),
        .busy_o                 (busy),
        .done_o                 (done),
        .pass_o                 (pass)
    );

    // params_mem model: synchronous write, read data RL cycles after the strobe.
    Param_t     mem [256];
    Param_t     rpipe [RL];
    logic       bd_en = 1'b0;
    ParamAddr_t bd_addr = '0;
    Param_t     bd_data = '0;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
        if (bd_en) mem[bd_addr] <= bd_data;
        rpipe[0] <= mem_read_en ? mem[mem_read_addr] : '0;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_read_data = rpipe[RL-1];

    typedef struct {
        ParamAddr_t a;
        Param_t     d;
    } wr_t;

    wr_t        exp_wr[$];
    ParamAddr_t exp_rd[$];
    bit         exp_pass[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference checksum straight from the rule cs = rotl(cs,1) ^ word.
    function automatic Param_t model_cs(input Param_t ws[$]);
        Param_t c = '0;
        foreach (ws[i]) c = ((c << 1) | (c >> (ParamWidth - 1))) ^ ws[i];
        return c;
    endfunction

    // Expected writes/reads of a full load, and its expected pass given what memory returns.
    task automatic plan(input ParamAddr_t a, input Param_t ws[$], input Param_t rd_ws[$]);
        foreach (ws[i]) begin
            exp_wr.push_back('{a: a + ParamAddr_t'(i), d: ws[i]});
            exp_rd.push_back(a + ParamAddr_t'(i));
        end
        exp_pass.push_back(model_cs(ws) == model_cs(rd_ws));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or done.
    initial begin
        wr_t e;
        ParamAddr_t ra;
        bit p;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n) begin
                if (mem_write_en || mem_read_en || mem_chip_en)
                    chk("chip_en", mem_chip_en, mem_write_en | mem_read_en);
                if (mem_write_en) begin
                    chk("rw_overlap", mem_read_en, 0);
                    if (exp_wr.size() == 0) chk("unexpected_write", mem_write_en, 0);
                    else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", mem_write_addr, e.a);
                        chk("wr_data", mem_write_data, e.d);
                    end
                end
                if (mem_read_en) begin
                    if (exp_rd.size() == 0) chk("unexpected_read", mem_read_en, 0);
                    else begin
                        ra = exp_rd.pop_front();
                        chk("rd_addr", mem_read_addr, ra);
                    end
                end
                if (done) begin
                    if (exp_pass.size() == 0) chk("unexpected_done", done, 0);
                    else begin
                        p = exp_pass.pop_front();
                        chk("done_pass", pass, p);
                    end
                end
            end
        end
    end

    task automatic do_start(input ParamAddr_t a, input ParamAddr_t n);
        start_addr = a;
        num_words  = n;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // gap_mode 0: no gaps, 1: idle cycle between words, 2: random gaps.
    task automatic stream(input Param_t ws[$], input int gap_mode);
        int k;
        foreach (ws[i]) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = ws[i];
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) chk("stream_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_read();
        int k = 0;
        while (!mem_read_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!mem_read_en) chk("read_timeout", mem_read_en, 1);
    endtask

    task automatic check_mem(input ParamAddr_t a, input Param_t ws[$]);
        foreach (ws[i]) chk("mem_readback", mem[a + ParamAddr_t'(i)], ws[i]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", mem_write_en, 0);
        chk("rst_re", mem_read_en, 0);
        chk("rst_ce", mem_chip_en, 0);
        chk("rst_waddr", mem_write_addr, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_raddr", mem_read_addr, 0);
        chk("rst_wwidth", 32'(mem_write_data_width), 32'(SINGLE_WIDTH));
        chk("rst_rwidth", 32'(mem_read_data_width), 32'(SINGLE_WIDTH));
    endtask

    function automatic void rand_words(input int n, output Param_t q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(Param_t'($urandom));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Param_t ws[$], rd[$], two[$], one[$];
        ParamAddr_t a;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n  = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // 1: basic load at 0x10
        ws = {16'h1, 16'h2, 16'h3, 16'h4};
        plan(8'h10, ws, ws);
        do_start(8'h10, 8'd4);
        stream(ws, 0);
        wait_idle();
        chk("t1_pass", pass, 1);
        check_mem(8'h10, ws);

        // 2: backdoor corruption of 0x12 before its read
        rd = ws;
        rd[2] = rd[2] ^ 16'hA5A5;
        plan(8'h10, ws, rd);
        do_start(8'h10, 8'd4);
        stream(ws, 0);
        wait_read();
        bd_en = 1'b1; bd_addr = 8'h12; bd_data = rd[2];
        @(negedge clk);
        bd_en = 1'b0;
        wait_idle();
        chk("t2_pass", pass, 0);

        // 3: gapped stream, in_ready must drop after the last acceptance
        rand_words(3, ws);
        plan(8'h40, ws, ws);
        do_start(8'h40, 8'd3);
        stream(ws, 1);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        chk("t3_in_ready_low", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        chk("t3_pass", pass, 1);
        check_mem(8'h40, ws);

        // 4: zero-length load, done two cycles after start
        ws = {};
        plan(8'h00, ws, ws);
        do_start(8'h55, 8'd0);
        chk("t4_busy", busy, 1);
        chk("t4_done_early", done, 0);
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_pass", pass, 1);
        @(negedge clk);

        // 5: address wrap
        rand_words(2, ws);
        plan(8'hFF, ws, ws);
        do_start(8'hFF, 8'd2);
        stream(ws, 0);
        wait_idle();
        chk("t5_pass", pass, 1);
        check_mem(8'hFF, ws);

        // 6: abort after 2 of 5 words, then a fresh 1-word load
        rand_words(5, ws);
        two = {ws[0], ws[1]};
        foreach (two[i]) exp_wr.push_back('{a: 8'h20 + ParamAddr_t'(i), d: two[i]});
        do_start(8'h20, 8'd5);
        stream(two, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_pass", pass, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_we", mem_write_en, 0);
        repeat (3) @(negedge clk);
        one = {ws[4]};
        plan(8'h30, one, one);
        do_start(8'h30, 8'd1);
        stream(one, 0);
        wait_idle();
        chk("t6_pass2", pass, 1);

        // Random loads with random gaps
        repeat (4) begin
            a = ParamAddr_t'($urandom);
            rand_words($urandom_range(1, 6), ws);
            plan(a, ws, ws);
            do_start(a, ParamAddr_t'(ws.size()));
            stream(ws, 2);
            wait_idle();
            chk("rand_pass", pass, 1);
            check_mem(a, ws);
        end
        chk("scoreboard_drained", exp_wr.size() + exp_rd.size() + exp_pass.size(), 0);

        // Async reset in the middle of VERIFY
        rand_words(4, ws);
        plan(8'h80, ws, ws);
        do_start(8'h80, 8'd4);
        stream(ws, 0);
        wait_read();
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_wr.delete();
        exp_rd.delete();
        exp_pass.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
